// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Boot-time program loader. Receives a byte stream from the UART receiver,
// frames it as 0xA5, a 4-byte little-endian word count N, then N little-endian
// 32-bit words. Each word is written to the instruction RAM at consecutive
// word-aligned byte addresses starting at 0. The core is held in reset while
// a load is in progress and released one cycle after the final write.
//
// Ports:
//   clk       in   single clock, all state changes on its rising edge
//   rst       in   synchronous active-high reset
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   rx_data   in   received byte
//   is_write  out  instruction RAM write enable, one-cycle pulse per word
//   im_addr   out  byte address of the write (word aligned)
//   im_inst   out  instruction word to write
//   core_rst  out  core reset request, high while loading or in error
//   busy      out  high in LEN, DATA and DONE
//   done      out  one-cycle pulse when a load completes
//   err       out  sticky abort flag (oversize length or inter-byte timeout)
// -----------------------------------------------------------------------------
module inst_loader #(
    parameter int w       = 32,
    parameter int DEPTH   = 2048,
    parameter int TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         is_write,
    output logic [w-1:0] im_addr,
    output logic [w-1:0] im_inst,
    output logic         core_rst,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    // Index must be able to hold DEPTH itself (post-increment of the last word).
    localparam int IW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t         r_state, w_state_next;
    logic [1:0]     r_byte_cnt, w_byte_cnt_next;
    logic [23:0]    r_shift, w_shift_next;
    logic [31:0]    r_len, w_len_next;
    logic [IW-1:0]  r_idx, w_idx_next;
    logic [TW-1:0]  r_tmo, w_tmo_next;
    logic           r_is_write, w_is_write_next;
    logic [w-1:0]   r_im_addr, w_im_addr_next;
    logic [w-1:0]   r_im_inst, w_im_inst_next;
    logic           r_core_rst, r_busy, r_done, r_err;

    // The incoming byte completes the word on top of the three held bytes.
    logic [31:0]    w_word;
    logic [IW-1:0]  w_idx_inc;
    logic           w_last_byte;

    assign w_word      = {rx_data, r_shift};
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_last_byte = (r_byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_is_write <= 1'b0;
            r_im_addr  <= '0;
            r_im_inst  <= '0;
            r_core_rst <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_shift    <= w_shift_next;
            r_len      <= w_len_next;
            r_idx      <= w_idx_next;
            r_tmo      <= w_tmo_next;
            r_is_write <= w_is_write_next;
            r_im_addr  <= w_im_addr_next;
            r_im_inst  <= w_im_inst_next;
            // Status outputs are a registered decode of the next state so
            // they line up with the state they describe.
            r_core_rst <= (w_state_next != S_IDLE);
            r_busy     <= (w_state_next == S_LEN) || (w_state_next == S_DATA) ||
                          (w_state_next == S_DONE);
            r_done     <= (w_state_next == S_DONE);
            r_err      <= (w_state_next == S_ERR);
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_shift_next    = r_shift;
        w_len_next      = r_len;
        w_idx_next      = r_idx;
        w_tmo_next      = r_tmo;
        w_is_write_next = 1'b0;
        w_im_addr_next  = r_im_addr;
        w_im_inst_next  = r_im_inst;

        case (r_state)
            S_IDLE, S_ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    w_state_next    = S_LEN;
                    w_byte_cnt_next = '0;
                    w_idx_next      = '0;
                    w_tmo_next      = '0;
                end
            end

            S_LEN, S_DATA: begin
                if (rx_valid) begin
                    w_tmo_next      = '0;
                    w_shift_next    = w_word[31:8];
                    w_byte_cnt_next = r_byte_cnt + 1'b1;
                    if (w_last_byte) begin
                        if (r_state == S_LEN) begin
                            w_len_next = w_word;
                            if (w_word == 32'd0)
                                w_state_next = S_DONE;
                            else if (w_word > 32'(DEPTH))
                                w_state_next = S_ERR;
                            else
                                w_state_next = S_DATA;
                        end else begin
                            w_is_write_next = 1'b1;
                            w_im_addr_next  = w'({r_idx, 2'b00});
                            w_im_inst_next  = w'(w_word);
                            w_idx_next      = w_idx_inc;
                            if (32'(w_idx_inc) == r_len)
                                w_state_next = S_DONE;
                        end
                    end
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    // This idle cycle is the TIMEOUT-th since the last byte;
                    // any partially assembled word is simply dropped.
                    w_state_next = S_ERR;
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign is_write = r_is_write;
    assign im_addr  = r_im_addr;
    assign im_inst  = r_im_inst;
    assign core_rst = r_core_rst;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
//
// Self-checking bench for inst_loader (DEPTH=2048, TIMEOUT=16). Frames from a
// vector table are streamed back-to-back; the expected RAM writes (address,
// data, cycle) are queued when a frame starts and popped by a monitor when
// is_write pulses. Hand-written sequences cover timeout and reset mid-load.
// -----------------------------------------------------------------------------
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        is_write;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;

    inst_loader #(
        .w       (32),
        .DEPTH   (2048),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .is_write (is_write),
        .im_addr  (im_addr),
        .im_inst  (im_inst),
        .core_rst (core_rst),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_vec    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write monitor: every is_write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (is_write === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_write: got addr=%h inst=%h at cycle %0d, required no write",
                         im_addr, im_inst, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("write addr=%h inst=%h cycle=%0d", im_addr, im_inst, cyc);
                check("write_addr", im_addr, mon_e.addr);
                check("write_inst", im_inst, mon_e.inst);
                check("write_cycle", cyc, mon_e.cyc);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Frame table: byte stream left-aligned in a 20-byte field, first byte MSB.
    typedef struct {
        int           n;
        logic [159:0] bytes;
        int           a5_pos;
        int           nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic [31:0]  w2;
        bit           exp_done;
        bit           exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic set_vec(input int idx, input int n, input logic [159:0] b, input int a5,
                           input int nw, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input bit d, input bit e);
        tbl[idx].n        = n;
        tbl[idx].bytes    = b;
        tbl[idx].a5_pos   = a5;
        tbl[idx].nw       = nw;
        tbl[idx].w0       = w0;
        tbl[idx].w1       = w1;
        tbl[idx].w2       = w2;
        tbl[idx].exp_done = d;
        tbl[idx].exp_err  = e;
    endtask

    function automatic logic [31:0] pick(input int v, input int k);
        if (k == 0) return tbl[v].w0;
        if (k == 1) return tbl[v].w1;
        return tbl[v].w2;
    endfunction

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic stop_rx();
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.inst = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    int c0;
    int t_last;
    int rise;

    initial begin
        // Basic load, zero length, oversize, recovery after error,
        // noise + 0xA5 as data, back-to-back three words.
        set_vec(0, 13, {104'hA5_02000000_13005000_9300A000, 56'h0}, 0, 2,
                32'h00500013, 32'h00A00093, 32'h0, 1'b1, 1'b0);
        set_vec(1, 5, {40'hA5_00000000, 120'h0}, 0, 0,
                32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        set_vec(2, 5, {40'hA5_01080000, 120'h0}, 0, 0,
                32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        set_vec(3, 9, {72'hA5_01000000_EFBEADDE, 88'h0}, 0, 1,
                32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0);
        set_vec(4, 11, {88'h1122_A5_01000000_A5A5A5A5, 72'h0}, 2, 1,
                32'hA5A5A5A5, 32'h0, 32'h0, 1'b1, 1'b0);
        set_vec(5, 17, {136'hA5_03000000_00010203_04050607_08090A0B, 24'h0}, 0, 3,
                32'h03020100, 32'h07060504, 32'h0B0A0908, 1'b1, 1'b0);

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_is_write", is_write, 1'b0);
        check("reset_im_addr", im_addr, 32'h0);
        check("reset_im_inst", im_inst, 32'h0);
        check("reset_core_rst", core_rst, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tbl[v].n; i++) begin
                send(tbl[v].bytes[159 - 8*i -: 8]);
                if (i == 0) begin
                    c0 = cyc;
                    for (int k = 0; k < tbl[v].nw; k++)
                        push_exp(32'(k * 4), pick(v, k), c0 + tbl[v].a5_pos + 9 + 4*k);
                end
            end
            stop_rx();
            @(negedge clk);
            $display("frame %0d: %0d bytes, done=%b err=%b core_rst=%b", v, tbl[v].n, done, err, core_rst);
            check("frame_end_done", done, tbl[v].exp_done);
            check("frame_end_busy", busy, tbl[v].exp_done);
            check("frame_end_err", err, tbl[v].exp_err);
            check("frame_end_core_rst", core_rst, 1'b1);
            @(negedge clk);
            check("after_done", done, 1'b0);
            check("after_busy", busy, 1'b0);
            check("after_core_rst", core_rst, tbl[v].exp_err);
            check("after_err", err, tbl[v].exp_err);
            repeat (4) @(negedge clk);
            check("frame_pending_writes", sb.size(), 0);
        end

        // Timeout: N=1, two data bytes, then silence. err rises 17 cycles
        // after the last byte and the partial word is never written.
        send(8'hA5); send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        send(8'h11); send(8'h22);
        t_last = cyc;
        stop_rx();
        rise = -1;
        for (int k = 0; k < 40 && rise < 0; k++) begin
            @(negedge clk);
            if (err === 1'b1) rise = cyc;
        end
        $display("timeout: last byte cycle %0d, err rose at cycle %0d", t_last, rise);
        check("timeout_err_cycle", rise, t_last + 17);
        check("timeout_core_rst", core_rst, 1'b1);
        check("timeout_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        check("timeout_err_sticky", err, 1'b1);

        // Reset mid-load: N=4, first word written, then one-cycle rst.
        send(8'hA5);
        c0 = cyc;
        push_exp(32'h0, 32'hDDCCBBAA, c0 + 9);
        send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        send(8'h01);
        stop_rx();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        $display("reset mid-load: core_rst=%b busy=%b err=%b im_inst=%h", core_rst, busy, err, im_inst);
        check("midrst_is_write", is_write, 1'b0);
        check("midrst_im_addr", im_addr, 32'h0);
        check("midrst_im_inst", im_inst, 32'h0);
        check("midrst_core_rst", core_rst, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_err", err, 1'b0);
        send(8'h13);
        send(8'h00);
        stop_rx();
        repeat (5) @(negedge clk);
        check("ignored_core_rst", core_rst, 1'b0);
        check("ignored_busy", busy, 1'b0);

        check("total_done_pulses", done_cnt, 5);
        check("final_pending_writes", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that drives the write port of the instruction RAM (`is_write`, `im_addr`, `im_inst`). It takes a byte stream from the UART receiver, frames it into 32-bit little-endian instruction words, and writes them to consecutive word addresses starting at 0. It holds the core in reset while a load is in progress and releases it once the last word is committed.

## Interface
Parameters:
- `w`, 32: instruction and address width.
- `DEPTH`, 2048: maximum number of words per load.
- `TIMEOUT`, 1000000: idle cycles allowed between bytes inside a frame before the load aborts.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `is_write` out 1: instruction RAM write enable; one-cycle pulse per word.
- `im_addr` out w: byte address of the write, always word-aligned.
- `im_inst` out w: instruction word to write.
- `core_rst` out 1: core reset request; high while loading.
- `busy` out 1: high in LEN, DATA, DONE.
- `done` out 1: one-cycle pulse when a load completes.
- `err` out 1: sticky abort flag.

## Operation
- States: IDLE, LEN, DATA, DONE, ERR. `rst` moves to IDLE.
- All outputs are registered. Reset values: `is_write`=0, `im_addr`=0, `im_inst`=0, `core_rst`=0, `busy`=0, `done`=0, `err`=0. Byte count, word index, length and timeout counter all reset to 0.
- IDLE:
  - Bytes other than 0xA5 are ignored.
  - 0xA5 moves to LEN, clears `err` and the word index, and sets `core_rst`=1.
- LEN:
  - Four bytes form N, LSB first.
  - After the 4th byte: if N=0, go to DONE; if N>DEPTH, go to ERR; otherwise go to DATA.
- DATA:
  - Bytes are assembled LSB first.
  - On the 4th byte of a word, the next cycle drives `is_write`=1, `im_inst`=assembled word and `im_addr`=index×4.
  - The index then increments.
  - After word N is written, go to DONE.
- DONE:
  - Lasts exactly one cycle with `done`=1 and `core_rst` still 1.
  - Then go to IDLE with `core_rst`=0.
- ERR:
  - `err`=1 and `core_rst` stays 1.
  - No writes are issued.
  - Only 0xA5 leaves ERR; it restarts the flow as from IDLE.
- Timeout:
  - In LEN or DATA, the counter increments each cycle without `rx_valid` and clears on `rx_valid`.
  - When it reaches TIMEOUT, go to ERR.
  - A partial word is discarded and never written.
- Byte value 0xA5 inside LEN or DATA is plain data, not a resync.
- `rst` during a load aborts immediately. Any write already pulsed stays in RAM. `core_rst` returns to 0.

## Timing
- `is_write`:
  - When the 4th byte of a word is strobed in cycle t, `is_write` is high in cycle t+1 only.
  - `im_addr` and `im_inst` are stable in cycle t+1 and hold their values until the next write.
- Last word:
  - The last word's `is_write` is in cycle t+1.
  - `done` is also high in cycle t+1 (DONE state).
  - `core_rst` falls in cycle t+2.
- N=0: the 4th length byte in cycle t gives `done` in t+1 and `core_rst` low in t+2. No `is_write` occurs.
- Back-to-back bytes: `rx_valid` may be high every cycle. A byte arriving in the same cycle as an `is_write` pulse must be accepted, not dropped.
- Byte throughput: 1 byte per cycle, i.e. up to 1 word per 4 cycles.
- Addresses: `im_addr` increases by 4 per word. The highest address is (DEPTH−1)×4; the N>DEPTH check prevents wrap.
- Timeout: aborts exactly TIMEOUT cycles after the last `rx_valid`, with `err` high the next cycle.

## Test plan
- **Basic load**
  - Stimulus: A5, 02 00 00 00, 13 00 50 00, 93 00 A0 00.
  - Response:
    - writes (addr 0x0, 0x00500013) then (addr 0x4, 0x00A00093);
    - `done` pulses once;
    - `core_rst` is high from the cycle after A5 until 1 cycle after `done`.
- **Zero length**
  - Stimulus: A5, 00 00 00 00.
  - Response: no `is_write`; `done` pulses 1 cycle after the 4th byte; `err`=0.
- **Oversize**
  - Stimulus: A5, then N=DEPTH+1 (01 08 00 00 at DEPTH=2048).
  - Response: ERR; `err`=1 and `core_rst`=1 held; no writes.
  - Follow-up: a fresh A5 + valid frame clears `err` and loads normally.
- **Timeout**
  - Stimulus: A5, N=1, then 2 data bytes and silence (use TIMEOUT=16).
  - Response: `err` rises 17 cycles after the last byte; no write.
- **Back-to-back**
  - Stimulus: `rx_valid` high every cycle for A5 + N=3 + 12 bytes 00..0B.
  - Response: writes 0x03020100 @0x0, 0x07060504 @0x4, 0x0B0A0908 @0x8, each exactly 4 cycles apart; no byte lost.
- **Reset mid-load**
  - Stimulus: assert `rst` for one cycle after the first word is written in an N=4 frame.
  - Response: all outputs take reset values the next cycle; a following non-A5 byte is ignored.
